// File: rtl/shared_rd_pkg.sv
// Shared definitions for the three-client shared read-port block:
// default widths, per-client lane offsets, client encoding and the
// fixed-priority pick used by the arbiter.
package shared_rd_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 32;
    localparam int LANE_W_DEF = 16;

    // Bit offset of each client's field within a storage word.
    localparam int LANE_OFF1 = 0;
    localparam int LANE_OFF2 = 8;
    localparam int LANE_OFF3 = 16;

    // Client identity, also used as the round-robin "last granted" pointer.
    typedef enum logic [1:0] {
        CLI1 = 2'd0,
        CLI2 = 2'd1,
        CLI3 = 2'd2
    } client_e;

    // Isolate the lowest set request bit: bit 0 has the highest priority.
    function automatic logic [2:0] fixed_pri3(input logic [2:0] req);
        return req & (~req + 3'd1);
    endfunction

endpackage

// File: rtl/shared_rd_arb3.sv
// Three-way arbiter for the shared read port: req[2:0] in, one-hot gnt out.
// Default build is fixed priority (bit 0 highest) with no state.
// Defining SHARED_RD_RR_EN adds a round-robin pointer: the search starts at
// the client after the last one granted, and reset leaves the pointer at
// client 3 so client 1 is favoured first.
module shared_rd_arb3
    import shared_rd_pkg::*;
(
`ifdef SHARED_RD_RR_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic [2:0] req,
    output logic [2:0] gnt
);

`ifdef SHARED_RD_RR_EN
    client_e    last_q;
    client_e    last_d;
    logic [2:0] pick;

    // Rotate the requests so the search starts after the last grant,
    // pick the lowest, rotate the grant back, and track the winner.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        pick   = 3'b000;
        gnt    = 3'b000;
        last_d = last_q;
        case (last_q)
            CLI1: begin
                pick = fixed_pri3({req[0], req[2], req[1]});
                gnt  = {pick[1], pick[0], pick[2]};
            end
            CLI2: begin
                pick = fixed_pri3({req[1], req[0], req[2]});
                gnt  = {pick[0], pick[2], pick[1]};
            end
            default: begin
                pick = fixed_pri3(req);
                gnt  = pick;
            end
        endcase
        if (gnt[0]) begin
            last_d = CLI1;
        end else if (gnt[1]) begin
            last_d = CLI2;
        end else if (gnt[2]) begin
            last_d = CLI3;
        end
    end

    // Round-robin pointer; only moves when something is granted.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            last_q <= CLI3;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: client 1 over client 2 over client 3.
    always_comb begin
        gnt = fixed_pri3(req);
    end
`endif

endmodule

// File: rtl/shared_rd_lanes.sv
// Single-read-port storage array shared by three clients. Each client sees
// a 16-bit lane of the 32-bit word (word[15:0], word[23:8], word[31:16]).
// Grants are combinational; data and a one-cycle valid pulse follow one
// cycle later. A read and a write to the same address in the same cycle
// return the old word.
// Optional macro SHARED_RD_RR_EN: round-robin instead of fixed priority.
module shared_rd_lanes
    import shared_rd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req1,
    input  logic              rd_req2,
    input  logic              rd_req3,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [ADDR_W-1:0] rd_addr3,
    output logic              rd_gnt1,
    output logic              rd_gnt2,
    output logic              rd_gnt3,
    output logic              rd_valid1,
    output logic              rd_valid2,
    output logic              rd_valid3,
    output logic [LANE_W-1:0] rd_data1,
    output logic [LANE_W-1:0] rd_data2,
    output logic [LANE_W-1:0] rd_data3
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [2:0]        req_m;
    logic [2:0]        gnt;
    logic [ADDR_W-1:0] rd_addr_sel;
    logic [DATA_W-1:0] rd_word;

    logic [2:0]        rd_valid_q, rd_valid_d;
    logic [LANE_W-1:0] rd_data1_q, rd_data1_d;
    logic [LANE_W-1:0] rd_data2_q, rd_data2_d;
    logic [LANE_W-1:0] rd_data3_q, rd_data3_d;

    // No client can win while reset is held.
    assign req_m = {rd_req3, rd_req2, rd_req1} & {3{~rst}};

    shared_rd_arb3 u_arb (
`ifdef SHARED_RD_RR_EN
        .clk (clk),
        .rst (rst),
`endif
        .req (req_m),
        .gnt (gnt)
    );

    assign rd_gnt1 = gnt[0];
    assign rd_gnt2 = gnt[1];
    assign rd_gnt3 = gnt[2];

    // Steer the winning client's address onto the single read port.
    always_comb begin
        rd_addr_sel = rd_addr1;
        if (gnt[1]) begin
            rd_addr_sel = rd_addr2;
        end else if (gnt[2]) begin
            rd_addr_sel = rd_addr3;
        end
    end

    // Read is taken before the edge, so a same-cycle write is not seen.
    assign rd_word = mem_q[rd_addr_sel];

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; its contents survive rst and it maps
        // onto plain RAM.
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Next-state for the per-client valid pulse and held lane data.
    always_comb begin
        rd_valid_d = gnt;
        rd_data1_d = gnt[0] ? rd_word[LANE_OFF1 +: LANE_W] : rd_data1_q;
        rd_data2_d = gnt[1] ? rd_word[LANE_OFF2 +: LANE_W] : rd_data2_q;
        rd_data3_d = gnt[2] ? rd_word[LANE_OFF3 +: LANE_W] : rd_data3_q;
    end

    // Response registers; reset clears any read that was in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 3'b000;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            rd_data3_q <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            rd_data3_q <= rd_data3_d;
        end
    end

    assign rd_valid1 = rd_valid_q[0];
    assign rd_valid2 = rd_valid_q[1];
    assign rd_valid3 = rd_valid_q[2];
    assign rd_data1  = rd_data1_q;
    assign rd_data2  = rd_data2_q;
    assign rd_data3  = rd_data3_q;

endmodule

// File: tb/tb_shared_rd_lanes.sv
// Scoreboard bench for shared_rd_lanes. Stimulus drives requests on the
// falling edge, checks the combinational grant and pushes the expected
// response; a separate monitor pops and compares whenever a valid appears.
// Build with SHARED_RD_RR_EN defined to also run the round-robin sequence.
module tb_shared_rd_lanes;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req1, rd_req2, rd_req3;
    logic [AW-1:0] rd_addr1, rd_addr2, rd_addr3;
    logic          rd_gnt1, rd_gnt2, rd_gnt3;
    logic          rd_valid1, rd_valid2, rd_valid3;
    logic [LW-1:0] rd_data1, rd_data2, rd_data3;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int            client;
        logic [LW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb_q[$];

    shared_rd_lanes dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req1   (rd_req1),
        .rd_req2   (rd_req2),
        .rd_req3   (rd_req3),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_addr3  (rd_addr3),
        .rd_gnt1   (rd_gnt1),
        .rd_gnt2   (rd_gnt2),
        .rd_gnt3   (rd_gnt3),
        .rd_valid1 (rd_valid1),
        .rd_valid2 (rd_valid2),
        .rd_valid3 (rd_valid3),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_data3  (rd_data3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: requests, addresses and an optional write.
    // The grant is checked straight away; a granted read queues its result.
    task automatic step(input string name, input logic [2:0] req,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [AW-1:0] a3, input logic we,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [2:0] exp_gnt, input logic [LW-1:0] exp_data);
        exp_t e;
        @(negedge clk);
        {rd_req3, rd_req2, rd_req1} = req;
        rd_addr1 = a1;
        rd_addr2 = a2;
        rd_addr3 = a3;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        #1;
        check({name, "_gnt"}, {29'd0, rd_gnt3, rd_gnt2, rd_gnt1}, {29'd0, exp_gnt});
        if (exp_gnt != 3'b000) begin
            e.client = exp_gnt[0] ? 0 : (exp_gnt[1] ? 1 : 2);
            e.data   = exp_data;
            e.due    = cyc + 1;
            sb_q.push_back(e);
        end
    endtask

    task automatic write_word(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        step("wr", 3'b000, '0, '0, '0, 1'b1, wa, wd, 3'b000, '0);
    endtask

    // Monitor: compare every valid pulse against the scoreboard head and
    // flag results that are late, missing or unexpected.
    initial begin : monitor
        logic [2:0]    v;
        logic [LW-1:0] d;
        exp_t          e;
        forever begin
            @(negedge clk);
            v = {rd_valid3, rd_valid2, rd_valid1};
            d = v[0] ? rd_data1 : (v[1] ? rd_data2 : rd_data3);
            if (v != 3'b000) begin
                check("one_valid", $countones(v), 1);
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", {29'd0, v}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("valid_client", {29'd0, v}, {29'd0, 3'b001 << e.client});
                    check("valid_cycle", cyc, e.due);
                    check("rd_data", {16'd0, d}, {16'd0, e.data});
                end
            end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                check("missing_valid", {29'd0, v}, {29'd0, 3'b001 << e.client});
            end
        end
    end

    initial begin : stimulus
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        {rd_req3, rd_req2, rd_req1} = 3'b000;
        rd_addr1 = '0;
        rd_addr2 = '0;
        rd_addr3 = '0;

        // Reset state, and no grants while rst is high even with requests.
        repeat (2) @(negedge clk);
        {rd_req3, rd_req2, rd_req1} = 3'b111;
        #1;
        check("rst_gnt", {29'd0, rd_gnt3, rd_gnt2, rd_gnt1}, 32'd0);
        check("rst_valid", {29'd0, rd_valid3, rd_valid2, rd_valid1}, 32'd0);
        check("rst_data1", {16'd0, rd_data1}, 32'd0);
        check("rst_data2", {16'd0, rd_data2}, 32'd0);
        check("rst_data3", {16'd0, rd_data3}, 32'd0);
        @(negedge clk);
        {rd_req3, rd_req2, rd_req1} = 3'b000;
        rst = 1'b0;

        write_word(4'd5, 32'hA1B2_C3D4);
        write_word(4'd1, 32'h1111_0000);
        write_word(4'd2, 32'h2222_0000);
        write_word(4'd3, 32'h3333_0000);
        write_word(4'd7, 32'h0000_FFFF);
        write_word(4'd9, 32'hDEAD_BEEF);

`ifdef SHARED_RD_RR_EN
        // Round-robin with clients 1 and 3 both requesting: 1,3,1,3.
        step("rr1", 3'b101, 4'd1, 4'd0, 4'd3, 1'b0, '0, '0, 3'b001, 16'h0000);
        step("rr2", 3'b101, 4'd1, 4'd0, 4'd3, 1'b0, '0, '0, 3'b100, 16'h3333);
        step("rr3", 3'b101, 4'd1, 4'd0, 4'd3, 1'b0, '0, '0, 3'b001, 16'h0000);
        step("rr4", 3'b101, 4'd1, 4'd0, 4'd3, 1'b0, '0, '0, 3'b100, 16'h3333);
`endif

        // All three request; each drops once granted: 1, 2, 3 back-to-back.
        step("pri1", 3'b111, 4'd1, 4'd2, 4'd3, 1'b0, '0, '0, 3'b001, 16'h0000);
        step("pri2", 3'b110, 4'd1, 4'd2, 4'd3, 1'b0, '0, '0, 3'b010, 16'h2200);
        step("pri3", 3'b100, 4'd1, 4'd2, 4'd3, 1'b0, '0, '0, 3'b100, 16'h3333);

        // Client 2 lane of 0xA1B2C3D4 is bits [23:8].
        step("c2_a5", 3'b010, 4'd0, 4'd5, 4'd0, 1'b0, '0, '0, 3'b010, 16'hB2C3);
        step("idle0", 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, '0, '0, 3'b000, '0);

        // Same client twice in a row, no bubble.
        step("b2b1", 3'b001, 4'd5, 4'd0, 4'd0, 1'b0, '0, '0, 3'b001, 16'hC3D4);
        step("b2b2", 3'b001, 4'd1, 4'd0, 4'd0, 1'b0, '0, '0, 3'b001, 16'h0000);

        // Read and write of addr 7 in one cycle returns the old word.
        step("rbw", 3'b001, 4'd7, 4'd0, 4'd0, 1'b1, 4'd7, 32'h1234_5678, 3'b001, 16'hFFFF);
        step("reread", 3'b001, 4'd7, 4'd0, 4'd0, 1'b0, '0, '0, 3'b001, 16'h5678);
        step("idle1", 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, '0, '0, 3'b000, '0);
        step("idle2", 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, '0, '0, 3'b000, '0);

        // Lane data holds between pulses.
        check("hold_data1", {16'd0, rd_data1}, 32'h5678);
        check("hold_data2", {16'd0, rd_data2}, 32'hB2C3);
        check("hold_data3", {16'd0, rd_data3}, 32'h3333);

        // Grant client 3, then reset in the next cycle: the read is dropped.
        @(negedge clk);
        {rd_req3, rd_req2, rd_req1} = 3'b100;
        rd_addr3 = 4'd9;
        #1;
        check("rst_drop_gnt", {29'd0, rd_gnt3, rd_gnt2, rd_gnt1}, 32'h4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        {rd_req3, rd_req2, rd_req1} = 3'b111;
        #1;
        check("rst_hi_gnt", {29'd0, rd_gnt3, rd_gnt2, rd_gnt1}, 32'd0);
        @(negedge clk);
        check("rst_hi_valid3", {31'd0, rd_valid3}, 32'd0);
        check("rst_hi_data3", {16'd0, rd_data3}, 32'd0);
        check("rst_hi_data1", {16'd0, rd_data1}, 32'd0);
        check("rst_hi_gnt2", {29'd0, rd_gnt3, rd_gnt2, rd_gnt1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        {rd_req3, rd_req2, rd_req1} = 3'b000;
        repeat (3) @(negedge clk);
        check("post_rst_valid3", {31'd0, rd_valid3}, 32'd0);
        check("post_rst_data3", {16'd0, rd_data3}, 32'd0);

        // Array contents survive reset.
        step("keep_a5", 3'b001, 4'd5, 4'd0, 4'd0, 1'b0, '0, '0, 3'b001, 16'hC3D4);
        step("keep_a9", 3'b100, 4'd0, 4'd0, 4'd9, 1'b0, '0, '0, 3'b100, 16'hDEAD);
        step("idle3", 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, '0, '0, 3'b000, '0);
        step("idle4", 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, '0, '0, 3'b000, '0);
        @(negedge clk);
        #1;
        check("sb_drain", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
